// File: rtl/fp_mul_pkg.sv
// rtl/fp_mul_pkg.sv - shared constants and FSM state type for the mantissa multiplier
package fp_mul_pkg;

    localparam int MANT_W = 24;
    localparam int PROD_W = 2 * MANT_W;
    localparam int CNT_W  = $clog2(MANT_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_step.sv
// rtl/shift_add_step.sv - one shift-add iteration: conditional add of mcand into the upper half, then right shift
module shift_add_step
    import fp_mul_pkg::*;
(
    input  logic [PROD_W-1:0] p,
    input  logic [MANT_W-1:0] mcand,
    output logic [PROD_W-1:0] p_next
);

    logic [MANT_W:0] sum;

    always_comb begin
        // The adder carry becomes the new MSB, so no product bit is lost in the shift.
        sum    = {1'b0, p[PROD_W-1:MANT_W]} + (p[0] ? {1'b0, mcand} : {(MANT_W+1){1'b0}});
        p_next = {sum, p[MANT_W-1:1]};
    end

endmodule

// File: rtl/seq_mant_mul.sv
// rtl/seq_mant_mul.sv - sequential 24x24 significand multiplier with start/done handshake
module seq_mant_mul
    import fp_mul_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] Abus,
    input  logic [31:0] Bbus,
    output logic        busy,
    output logic        done,
    output logic [47:0] resultbus_seq_mul
);

    state_t              state_q, state_d;
    logic [MANT_W-1:0]   mcand_q, mcand_d;
    logic [PROD_W-1:0]   p_q, p_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PROD_W-1:0]   result_q, result_d;
    logic [PROD_W-1:0]   p_step;

    shift_add_step u_step (
        .p      (p_q),
        .mcand  (mcand_q),
        .p_next (p_step)
    );

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                // Hidden bit is forced to 1; sign and exponent fields are dropped here.
                if (start) begin
                    mcand_d = {1'b1, Abus[22:0]};
                    p_d     = {{MANT_W{1'b0}}, 1'b1, Bbus[22:0]};
                    cnt_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                p_d   = p_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(MANT_W - 1)) begin
                    state_d  = DONE;
                    result_d = p_step;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy              = (state_q == MUL);
    assign done              = (state_q == DONE);
    assign resultbus_seq_mul = result_q;

endmodule

// File: tb/tb_seq_mant_mul.sv
// tb/tb_seq_mant_mul.sv - directed scoreboard bench for seq_mant_mul
module tb_seq_mant_mul;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] Abus;
    logic [31:0] Bbus;
    logic        busy;
    logic        done;
    logic [47:0] resultbus_seq_mul;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [47:0] exp_q[$];

    int          dcyc;
    int          bcnt;
    logic        held_ok;
    logic        no_done;
    logic [47:0] first_res;

    seq_mant_mul dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .Abus              (Abus),
        .Bbus              (Bbus),
        .busy              (busy),
        .done              (done),
        .resultbus_seq_mul (resultbus_seq_mul)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] ma;
        logic [47:0] mb;
        ma = {24'd0, 1'b1, a[22:0]};
        mb = {24'd0, 1'b1, b[22:0]};
        return ma * mb;
    endfunction

    // Drive an accepted start for one edge and record the expected product.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        Abus  = a;
        Bbus  = b;
        start = 1'b1;
        exp_q.push_back(model(a, b));
        tick();
        start = 1'b0;
    endtask

    // Called in cycle 1 of an operation; returns in the done cycle (or after the bound).
    task automatic wait_done(input string tag, input int repulse,
                             output int done_cyc, output int busy_cnt, output logic hold_ok);
        logic [47:0] held;
        logic [47:0] e;
        held     = resultbus_seq_mul;
        done_cyc = -1;
        busy_cnt = 0;
        hold_ok  = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (busy) busy_cnt++;
            if (resultbus_seq_mul !== held) hold_ok = 1'b0;
            if (cyc == repulse) begin
                Abus  = 32'h3F800000;
                Bbus  = 32'h3F800000;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        if (done_cyc < 0) begin
            check({tag, "_timeout"}, 64'(done_cyc), 64'd25);
        end else if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_result"}, 64'(resultbus_seq_mul), 64'(e));
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        Abus  = '0;
        Bbus  = '0;
        tick();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", 64'(resultbus_seq_mul), 64'd0);
        rst = 1'b0;
        tick();

        // 1.0 x 1.0 with latency and busy window
        launch(32'h3F800000, 32'h3F800000);
        wait_done("one_x_one", -1, dcyc, bcnt, held_ok);
        check("one_x_one_latency", 64'(dcyc), 64'd25);
        check("one_x_one_busy_cycles", 64'(bcnt), 64'd24);
        check("one_x_one_busy_in_done", 64'(busy), 64'd0);
        check("one_x_one_const", 64'(resultbus_seq_mul), 64'h4000_0000_0000);
        tick();
        check("idle_done_low", 64'(done), 64'd0);
        check("idle_result_held", 64'(resultbus_seq_mul), 64'h4000_0000_0000);

        launch(32'h3FC00000, 32'h3FC00000);
        wait_done("onefive_sq", -1, dcyc, bcnt, held_ok);
        check("onefive_sq_const", 64'(resultbus_seq_mul), 64'h9000_0000_0000);
        tick();

        launch(32'hBFC00000, 32'h3FC00000);
        wait_done("sign_ignored", -1, dcyc, bcnt, held_ok);
        check("sign_ignored_const", 64'(resultbus_seq_mul), 64'h9000_0000_0000);
        tick();

        launch(32'h3FFFFFFF, 32'h7F7FFFFF);
        wait_done("all_ones", -1, dcyc, bcnt, held_ok);
        check("all_ones_const", 64'(resultbus_seq_mul), 64'hFFFF_FE00_0001);
        tick();

        // Exponent field 0 still gets a hidden 1
        launch(32'h00400000, 32'h00000001);
        wait_done("zero_exp", -1, dcyc, bcnt, held_ok);
        tick();

        // start during MUL is ignored
        launch(32'h3FC00000, 32'h3FC00000);
        wait_done("ignored_start", 10, dcyc, bcnt, held_ok);
        check("ignored_start_latency", 64'(dcyc), 64'd25);
        check("ignored_start_const", 64'(resultbus_seq_mul), 64'h9000_0000_0000);
        tick();
        check("ignored_start_no_rerun", 64'(busy), 64'd0);
        tick();

        // back-to-back: start held in the DONE cycle
        launch(32'h3FC00000, 32'h3FC00000);
        wait_done("b2b_first", -1, dcyc, bcnt, held_ok);
        first_res = resultbus_seq_mul;
        launch(32'h3F800000, 32'h3F800000);
        check("b2b_busy_after_done", 64'(busy), 64'd1);
        wait_done("b2b_second", -1, dcyc, bcnt, held_ok);
        check("b2b_second_latency", 64'(dcyc), 64'd25);
        check("b2b_first_held", 64'(held_ok), 64'd1);
        check("b2b_first_value", 64'(first_res), 64'h9000_0000_0000);
        check("b2b_second_const", 64'(resultbus_seq_mul), 64'h4000_0000_0000);
        tick();

        // reset in cycle 12 aborts
        launch(32'h3FFFFFFF, 32'h7F7FFFFF);
        for (int i = 0; i < 11; i++) tick();
        check("pre_abort_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_result", 64'(resultbus_seq_mul), 64'd0);
        no_done = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (done || busy) no_done = 1'b0;
            tick();
        end
        check("abort_no_done", 64'(no_done), 64'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
